openip_stream_demux: RTL

Packet-aware one-to-many stream demultiplexer; the distribution-side counterpart to the many-to-one priority arbitration used in front of shared resources. Accepts one valid/ready stream carrying a per-packet destination mask and delivers each packet, beat by beat, to exactly one of N downstream ports through a single registered output stage. The destination is resolved on the head beat and locked until the last beat, so packets are never split across ports.

---
 rtl/openip_stream_demux_pkg.sv | 11 +
 rtl/openip_priority_arbiter.sv | 12 +
 rtl/openip_stream_demux.sv | 117 +++++++++++
 3 files changed

// File: rtl/openip_stream_demux_pkg.sv
// Shared types for openip_stream_demux: packet-tracking state encoding.
// OPENIP_STREAM_DEMUX_DROP_EN enables the ST_DROP path in the top module.
package openip_stream_demux_pkg;

    typedef enum logic [1:0] {
        ST_HEAD = 2'd0,
        ST_BODY = 2'd1,
        ST_DROP = 2'd2
    } state_e;

endpackage

// File: rtl/openip_priority_arbiter.sv
// Fixed-priority arbiter: grants the lowest-indexed active request (one-hot or zero).
module openip_priority_arbiter #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] req_i,
    output logic [WIDTH-1:0] gnt_o
);

    // Two's complement isolates the lowest set bit.
    assign gnt_o = req_i & (-req_i);

endmodule

// File: rtl/openip_stream_demux.sv
// Packet-aware 1:N stream demux with a single registered output stage.
// Define OPENIP_STREAM_DEMUX_DROP_EN to discard zero-destination packets and flag error.
module openip_stream_demux
    import openip_stream_demux_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int N     = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    input  logic [N-1:0]     in_dest,
    output logic [N-1:0]     out_valid,
    input  logic [N-1:0]     out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic             error,
    output state_e           dbg_state_o
);

    // Handshake: a beat moves when valid & ready are both high on a rising edge.
    state_e           state_q, state_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             last_q, last_d;
    logic [N-1:0]     sel_q, sel_d;
    logic             error_q, error_d;

    logic [N-1:0] head_gnt;
    logic [N-1:0] head_sel;
    logic         bad_head;
    logic         fire_out;
    logic         fire_in;

    openip_priority_arbiter #(
        .WIDTH (N)
    ) u_head_arb (
        .req_i (in_dest),
        .gnt_o (head_gnt)
    );

`ifdef OPENIP_STREAM_DEMUX_DROP_EN
    assign bad_head = (in_dest == '0);
`else
    assign bad_head = 1'b0;
`endif

    // A zero mask only reaches here when dropping is disabled; it falls back to port 0.
    assign head_sel = (in_dest == '0) ? N'(1) : head_gnt;

    assign fire_out = valid_q & |(sel_q & out_ready);
    assign in_ready = ~valid_q | fire_out;
    assign fire_in  = in_valid & in_ready;

    always_comb begin
        state_d = state_q;
        valid_d = valid_q & ~fire_out;
        data_d  = data_q;
        last_d  = last_q;
        sel_d   = sel_q;
        error_d = error_q;
        if (fire_in) begin
            case (state_q)
                ST_HEAD: begin
                    if (bad_head) begin
                        error_d = 1'b1;
                        if (!in_last) state_d = ST_DROP;
                    end else begin
                        valid_d = 1'b1;
                        data_d  = in_data;
                        last_d  = in_last;
                        sel_d   = head_sel;
                        if (!in_last) state_d = ST_BODY;
                    end
                end
                ST_BODY: begin
                    valid_d = 1'b1;
                    data_d  = in_data;
                    last_d  = in_last;
                    if (in_last) state_d = ST_HEAD;
                end
                ST_DROP: begin
                    if (in_last) state_d = ST_HEAD;
                end
                default: state_d = ST_HEAD;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_HEAD;
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
            sel_q   <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            last_q  <= last_d;
            sel_q   <= sel_d;
            error_q <= error_d;
        end
    end

    assign out_valid   = valid_q ? sel_q : '0;
    assign out_data    = data_q;
    assign out_last    = last_q;
    assign error       = error_q;
    assign dbg_state_o = state_q;

endmodule
